// File: rtl/apb_master.sv
// Single-outstanding APB master: converts a valid/ready command stream into
// APB setup/access transfers with a watchdog, returning one response per command.
module apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        pclk,
   input  logic        prset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] paddr,
   output logic [7:0]  pwdata,
   input  logic        pready,
   input  logic [7:0]  pread,
   input  logic        perr
);

   // Counter keeps at least one bit so a disabled watchdog still elaborates.
   localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pwrite_q, pwrite_d;
   logic [31:0]   paddr_q, paddr_d;
   logic [7:0]    pwdata_q, pwdata_d;
   logic [7:0]    rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;
   logic          rsp_timeout_q, rsp_timeout_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               cnt_d    = '0;
               state_d  = S_SETUP;
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
            // pready wins over the watchdog when both hit on the same edge.
            if (pready) begin
               rsp_rdata_d   = (pwrite_q || perr) ? '0 : pread;
               rsp_err_d     = perr;
               rsp_timeout_d = 1'b0;
               state_d       = S_RESP;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (prset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready   = (state_q == S_IDLE) && !prset;
   assign psel        = (state_q == S_SETUP) || (state_q == S_ACCESS);
   assign penable     = (state_q == S_ACCESS);
   assign rsp_valid   = (state_q == S_RESP);
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, randomized transfers against a
// transaction-level model, and reset-abort / backpressure sequences.
module tb_apb_master;

   logic        pclk = 1'b0;
   logic        prset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic        psel, penable, pwrite;
   logic [31:0] paddr;
   logic [7:0]  pwdata;
   logic        pready;
   logic [7:0]  pread;
   logic        perr;

   int unsigned n_vec = 0;
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   always #5 pclk = ~pclk;

   apb_master #(.TIMEOUT_CYCLES(4)) dut (
      .pclk(pclk), .prset(prset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .pread(pread), .perr(perr)
   );

   // Stub slave: 16 x 8-bit memory, programmable wait states, perr above 15.
   logic [7:0]  smem [16];
   int unsigned swait = 0;
   int unsigned scnt = 0;

   assign pready = psel && penable && (scnt >= swait);
   assign pread  = smem[paddr[3:0]];
   assign perr   = paddr > 32'd15;

   always @(posedge pclk) begin
      if (psel && penable && !pready) scnt <= scnt + 1;
      else scnt <= 0;
      if (psel && penable && pready && pwrite && !perr) smem[paddr[3:0]] <= pwdata;
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  wdata;
      int unsigned waits;
      int unsigned hold;
      logic [7:0]  e_rdata;
      logic        e_err;
      logic        e_to;
      int unsigned e_lat;
   } vec_t;

   vec_t tbl[8];
   logic [7:0] mdl_mem [16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Transaction-level model: outcome follows from the wait count and address alone.
   task automatic mk_vec(input logic wr, input logic [31:0] addr, input logic [7:0] wdata,
                         input int unsigned waits, input int unsigned hold, output vec_t v);
      logic to, err;
      to  = (waits >= 4);
      err = to || (addr > 32'd15);
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.hold = hold;
      v.e_to    = to;
      v.e_err   = err;
      v.e_rdata = (wr || err) ? 8'h00 : mdl_mem[addr[3:0]];
      v.e_lat   = 3 + (to ? 3 : waits);
      if (wr && !err) mdl_mem[addr[3:0]] = wdata;
   endtask

   task automatic run_xfer(input vec_t v);
      int unsigned cyc;
      int unsigned guard;
      logic ok;
      n_vec++;
      swait = v.waits;
      guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(posedge pclk); #1; guard++;
      end
      chk("cmd_ready_before", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
      rsp_ready = (v.hold == 0);
      @(posedge pclk); #1;
      cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = $urandom; cmd_wdata = 8'($urandom);
      cyc = 1; ok = 1'b1;
      while (!rsp_valid && cyc < 40) begin
         if (!psel || (penable !== (cyc > 1)) || paddr !== v.addr || pwrite !== v.wr ||
             pwdata !== v.wdata || cmd_ready) ok = 1'b0;
         @(posedge pclk); #1; cyc++;
      end
      chk("apb_phase_seq", ok, 1);
      chk("rsp_latency", cyc, v.e_lat);
      chk("resp_psel_penable", {psel, penable}, 2'b00);
      chk("rsp_rdata", rsp_rdata, v.e_rdata);
      chk("rsp_err", rsp_err, v.e_err);
      chk("rsp_timeout", rsp_timeout, v.e_to);
      ok = 1'b1;
      for (int unsigned i = 0; i < v.hold; i++) begin
         @(posedge pclk); #1;
         if (!rsp_valid || cmd_ready || rsp_rdata !== v.e_rdata || rsp_err !== v.e_err ||
             rsp_timeout !== v.e_to || paddr !== v.addr || psel) ok = 1'b0;
      end
      if (v.hold != 0) chk("backpressure_hold", ok, 1);
      rsp_ready = 1'b1;
      @(posedge pclk); #1;
      chk("rsp_handshake_drop", rsp_valid, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      vec_t v;
      logic ok;
      logic [31:0] a;
      int unsigned r, w;

      prset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      chk("reset_cmd_ready", cmd_ready, 0);
      chk("reset_apb_ctl", {psel, penable, pwrite}, 3'b000);
      chk("reset_paddr", paddr, 0);
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
      prset = 1'b0;
      @(posedge pclk); #1;
      chk("post_reset_cmd_ready", cmd_ready, 1);

      //              wr    addr       wdata  waits hold rdata  err   to  lat
      tbl[0] = '{1'b1, 32'd5,     8'hA5, 0,   0,   8'h00, 1'b0, 1'b0, 3};
      tbl[1] = '{1'b0, 32'd5,     8'h00, 0,   5,   8'hA5, 1'b0, 1'b0, 3};
      tbl[2] = '{1'b0, 32'h20,    8'h00, 1,   0,   8'h00, 1'b1, 1'b0, 4};
      tbl[3] = '{1'b1, 32'd7,     8'h3C, 2,   0,   8'h00, 1'b0, 1'b0, 5};
      tbl[4] = '{1'b0, 32'd7,     8'h11, 3,   1,   8'h3C, 1'b0, 1'b0, 6};
      tbl[5] = '{1'b0, 32'd9,     8'h00, 255, 2,   8'h00, 1'b1, 1'b1, 6};
      tbl[6] = '{1'b1, 32'h1F,    8'hEE, 0,   0,   8'h00, 1'b1, 1'b0, 3};
      tbl[7] = '{1'b0, 32'd5,     8'h00, 0,   0,   8'hA5, 1'b0, 1'b0, 3};
      for (int unsigned i = 0; i < 8; i++) run_xfer(tbl[i]);

      // Reset during ACCESS with a stalled slave: nothing must come back.
      swait = 255;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd3; cmd_wdata = 8'h77;
      @(posedge pclk); #1;
      cmd_valid = 1'b0;
      @(posedge pclk); #1;
      chk("abort_in_access", {psel, penable}, 2'b11);
      prset = 1'b1;
      @(posedge pclk); #1;
      chk("abort_apb_ctl", {psel, penable, pwrite}, 3'b000);
      chk("abort_paddr_pwdata", {paddr, pwdata}, 0);
      chk("abort_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
      chk("abort_cmd_ready", cmd_ready, 0);
      prset = 1'b0;
      ok = 1'b1;
      for (int unsigned i = 0; i < 8; i++) begin
         @(posedge pclk); #1;
         if (rsp_valid || psel || !cmd_ready) ok = 1'b0;
      end
      chk("abort_no_response", ok, 1);

      for (int unsigned i = 0; i < 16; i++) begin
         mk_vec(1'b1, i, 8'($urandom), 0, 0, v);
         run_xfer(v);
      end

      for (int unsigned i = 0; i < 150; i++) begin
         a = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h10) : $urandom_range(0, 15);
         r = $urandom_range(0, 9);
         if (r < 5) w = 0;
         else if (r < 7) w = $urandom_range(1, 3);
         else if (r == 7) w = 4;
         else if (r == 8) w = 255;
         else w = 3;
         mk_vec(1'($urandom_range(0, 1)), a, 8'($urandom), w, $urandom_range(0, 3), v);
         run_xfer(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
